// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if: EX/MEM inputs, dcache port and MEM/WB outputs of the MEM-stage controller.
interface mem_stage_ctrl_if;
  logic        dmemREN_EX_MEM, dmemWEN_EX_MEM;
  logic [31:0] dmemaddr_EX_MEM, dmemstore_EX_MEM, result_EX_MEM, next_imemaddr_EX_MEM;
  logic        WEN_EX_MEM;
  logic [1:0]  reg_dest_EX_MEM, mem_to_reg_EX_MEM;
  logic [4:0]  Rt_EX_MEM, Rd_EX_MEM;
  logic        halt_EX_MEM, datomic_EX_MEM, enable_MEM_WB, flush_MEM_WB;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_stall;
  logic        WEN_MEM_WB;
  logic [4:0]  wsel_MEM_WB;
  logic [31:0] wdat_MEM_WB;
  logic        halt_MEM_WB;
  modport slave (
    input  dmemREN_EX_MEM, dmemWEN_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM, result_EX_MEM,
           next_imemaddr_EX_MEM, WEN_EX_MEM, reg_dest_EX_MEM, mem_to_reg_EX_MEM, Rt_EX_MEM,
           Rd_EX_MEM, halt_EX_MEM, datomic_EX_MEM, enable_MEM_WB, flush_MEM_WB, dhit, dmemload,
    output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, WEN_MEM_WB, wsel_MEM_WB,
           wdat_MEM_WB, halt_MEM_WB
  );
  modport master (
    output dmemREN_EX_MEM, dmemWEN_EX_MEM, dmemaddr_EX_MEM, dmemstore_EX_MEM, result_EX_MEM,
           next_imemaddr_EX_MEM, WEN_EX_MEM, reg_dest_EX_MEM, mem_to_reg_EX_MEM, Rt_EX_MEM,
           Rd_EX_MEM, halt_EX_MEM, datomic_EX_MEM, enable_MEM_WB, flush_MEM_WB, dhit, dmemload,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall, WEN_MEM_WB, wsel_MEM_WB,
           wdat_MEM_WB, halt_MEM_WB
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM-stage dcache access FSM plus MEM/WB pipeline register.
// Optional LL/SC link register when LLSC_EN is defined.
module mem_stage_ctrl (
  input logic CLK,
  input logic nRST,
  mem_stage_ctrl_if.slave bus
);
  localparam logic [1:0] SEL_RD = 2'd0, SEL_RT = 2'd1;
  localparam logic [1:0] SEL_RESULT = 2'd0, SEL_DLOAD = 2'd1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE, S_HALT} state_t;
  state_t r_state, w_next;
  logic [31:0] r_hold, r_wdat, w_wdat;
  logic [4:0] r_wsel, w_wsel;
  logic r_wen, r_halt;
  logic w_active, w_ren, w_wen, w_req, w_stall, w_cap, w_done_acc, w_sc, w_sc_ok;
  assign w_active = nRST & (r_state == S_IDLE || r_state == S_WAIT);
  // Write wins when both strobes are requested.
  assign w_ren = bus.dmemREN_EX_MEM & ~bus.dmemWEN_EX_MEM;
  assign w_wen = bus.dmemWEN_EX_MEM & ~(w_sc & ~w_sc_ok);
  assign w_req = w_ren | w_wen;
  assign w_stall = w_active & w_req & ~bus.dhit;
  assign w_done_acc = w_active & w_req & bus.dhit;
  assign w_cap = bus.enable_MEM_WB & ~bus.flush_MEM_WB & ~w_stall;
`ifdef LLSC_EN
  logic r_link_valid, r_sc_ok;
  logic [31:0] r_link_addr;
  assign w_sc = bus.dmemWEN_EX_MEM & bus.datomic_EX_MEM;
  // Once in DONE the link is already consumed, so replay the recorded SC outcome.
  assign w_sc_ok = (r_state == S_DONE) ? r_sc_ok : r_link_valid && r_link_addr == bus.dmemaddr_EX_MEM;
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_link_valid <= 1'b0;
      r_link_addr <= '0;
      r_sc_ok <= 1'b0;
    end else if (w_done_acc) begin
      r_sc_ok <= w_sc_ok;
      if (w_ren & bus.datomic_EX_MEM) begin
        r_link_valid <= 1'b1;
        r_link_addr <= bus.dmemaddr_EX_MEM;
      end else if (w_wen & (w_sc | bus.dmemaddr_EX_MEM == r_link_addr)) r_link_valid <= 1'b0;
    end
`else
  logic w_unused;
  assign w_unused = bus.datomic_EX_MEM;
  assign w_sc = 1'b0;
  assign w_sc_ok = 1'b0;
`endif
  assign bus.dmemREN = w_active & w_ren;
  assign bus.dmemWEN = w_active & w_wen;
  assign bus.dmemaddr = bus.dmemaddr_EX_MEM;
  assign bus.dmemstore = bus.dmemstore_EX_MEM;
  assign bus.mem_stall = w_stall;
  assign bus.WEN_MEM_WB = r_wen;
  assign bus.wsel_MEM_WB = r_wsel;
  assign bus.wdat_MEM_WB = r_wdat;
  assign bus.halt_MEM_WB = r_halt;
  assign w_wsel = bus.reg_dest_EX_MEM == SEL_RD ? bus.Rd_EX_MEM :
                  bus.reg_dest_EX_MEM == SEL_RT ? bus.Rt_EX_MEM : 5'd31;
  assign w_wdat = w_sc ? {31'b0, w_sc_ok} :
                  bus.mem_to_reg_EX_MEM == SEL_RESULT ? bus.result_EX_MEM :
                  bus.mem_to_reg_EX_MEM == SEL_DLOAD ? (r_state == S_DONE ? r_hold : bus.dmemload) :
                  bus.next_imemaddr_EX_MEM;
  always_comb begin
    w_next = r_state;
    if (r_state == S_IDLE && w_req) w_next = bus.dhit ? (bus.enable_MEM_WB ? S_IDLE : S_DONE) : S_WAIT;
    else if (r_state == S_WAIT && bus.dhit) w_next = bus.enable_MEM_WB ? S_IDLE : S_DONE;
    else if (r_state == S_DONE && bus.enable_MEM_WB) w_next = S_IDLE;
    if (w_cap && bus.halt_EX_MEM) w_next = S_HALT;
  end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_state <= S_IDLE;
      r_hold <= '0;
    end else begin
      r_state <= w_next;
      if (w_done_acc) r_hold <= bus.dmemload;
    end
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      r_wen <= 1'b0;
      r_wsel <= '0;
      r_wdat <= '0;
      r_halt <= 1'b0;
    end else if (bus.flush_MEM_WB) begin
      r_wen <= 1'b0;
      r_wsel <= '0;
      r_wdat <= '0;
    end else if (w_stall) r_wen <= 1'b0;
    else if (bus.enable_MEM_WB) begin
      r_wen <= bus.WEN_EX_MEM;
      r_wsel <= w_wsel;
      r_wdat <= w_wdat;
      r_halt <= r_halt | bus.halt_EX_MEM;
    end
  a_no_dual_strobe: assert property (@(posedge CLK) disable iff (!nRST)
    !(bus.dmemREN_EX_MEM && bus.dmemWEN_EX_MEM));
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed checks of the MEM-stage controller and MEM/WB register.
module tb_mem_stage_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  mem_stage_ctrl_if bus ();
  mem_stage_ctrl dut (.CLK(clk), .nRST(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.dmemREN_EX_MEM = 0; bus.dmemWEN_EX_MEM = 0; bus.dmemaddr_EX_MEM = 0;
    bus.dmemstore_EX_MEM = 0; bus.result_EX_MEM = 0; bus.next_imemaddr_EX_MEM = 0;
    bus.WEN_EX_MEM = 0; bus.reg_dest_EX_MEM = 0; bus.mem_to_reg_EX_MEM = 0;
    bus.Rt_EX_MEM = 0; bus.Rd_EX_MEM = 0; bus.halt_EX_MEM = 0; bus.datomic_EX_MEM = 0;
    bus.enable_MEM_WB = 1; bus.flush_MEM_WB = 0; bus.dhit = 0; bus.dmemload = 0;
  endtask

  initial begin
    idle_inputs();
    step(); step();
    chk("rst_ren", bus.dmemREN, 0);
    chk("rst_wen", bus.dmemWEN, 0);
    chk("rst_stall", bus.mem_stall, 0);
    chk("rst_wenwb", bus.WEN_MEM_WB, 0);
    chk("rst_wsel", bus.wsel_MEM_WB, 0);
    chk("rst_wdat", bus.wdat_MEM_WB, 0);
    chk("rst_halt", bus.halt_MEM_WB, 0);
    rst_n = 1;
    step();
    // LW 0x40, same-cycle hit
    bus.dmemREN_EX_MEM = 1; bus.dmemaddr_EX_MEM = 32'h40; bus.dhit = 1;
    bus.dmemload = 32'hDEADBEEF; bus.reg_dest_EX_MEM = 2'd1; bus.Rt_EX_MEM = 5'd5;
    bus.mem_to_reg_EX_MEM = 2'd1; bus.WEN_EX_MEM = 1;
    #1;
    chk("lw_ren", bus.dmemREN, 1);
    chk("lw_addr", bus.dmemaddr, 32'h40);
    chk("lw_stall", bus.mem_stall, 0);
    step();
    idle_inputs();
    chk("lw_wenwb", bus.WEN_MEM_WB, 1);
    chk("lw_wsel", bus.wsel_MEM_WB, 5);
    chk("lw_wdat", bus.wdat_MEM_WB, 32'hDEADBEEF);
    // SW 0x80, hit after 3 stall cycles
    bus.dmemWEN_EX_MEM = 1; bus.dmemaddr_EX_MEM = 32'h80; bus.dmemstore_EX_MEM = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sw_stall", bus.mem_stall, 1);
      chk("sw_wen", bus.dmemWEN, 1);
      step();
      chk("sw_wenwb", bus.WEN_MEM_WB, 0);
    end
    bus.dhit = 1;
    #1;
    chk("sw_hit_stall", bus.mem_stall, 0);
    chk("sw_hit_wen", bus.dmemWEN, 1);
    chk("sw_store", bus.dmemstore, 32'h1234);
    step();
    idle_inputs();
    chk("sw_done_wenwb", bus.WEN_MEM_WB, 0);
    // LW hit while MEM/WB disabled for 2 cycles
    bus.dmemREN_EX_MEM = 1; bus.dmemaddr_EX_MEM = 32'hC0; bus.dhit = 1;
    bus.dmemload = 32'hCAFEF00D; bus.mem_to_reg_EX_MEM = 2'd1; bus.reg_dest_EX_MEM = 2'd0;
    bus.Rd_EX_MEM = 5'd7; bus.WEN_EX_MEM = 1; bus.enable_MEM_WB = 0;
    #1;
    chk("hold_ren0", bus.dmemREN, 1);
    chk("hold_stall0", bus.mem_stall, 0);
    step();
    bus.dhit = 0; bus.dmemload = 32'h11111111;
    #1;
    chk("hold_ren1", bus.dmemREN, 0);
    chk("hold_stall1", bus.mem_stall, 0);
    step();
    chk("hold_ren2", bus.dmemREN, 0);
    chk("hold_wenwb", bus.WEN_MEM_WB, 0);
    bus.enable_MEM_WB = 1;
    step();
    idle_inputs();
    chk("hold_wdat", bus.wdat_MEM_WB, 32'hCAFEF00D);
    chk("hold_wsel", bus.wsel_MEM_WB, 7);
    chk("hold_wenwb2", bus.WEN_MEM_WB, 1);
    // flush and enable together
    bus.result_EX_MEM = 32'h7; bus.WEN_EX_MEM = 1; bus.flush_MEM_WB = 1;
    step();
    chk("flush_wenwb", bus.WEN_MEM_WB, 0);
    chk("flush_wdat", bus.wdat_MEM_WB, 0);
    chk("flush_wsel", bus.wsel_MEM_WB, 0);
    bus.flush_MEM_WB = 0; bus.result_EX_MEM = 32'h55; bus.reg_dest_EX_MEM = 2'd2;
    step();
    chk("r31_wsel", bus.wsel_MEM_WB, 31);
    chk("r31_wdat", bus.wdat_MEM_WB, 32'h55);
    bus.mem_to_reg_EX_MEM = 2'd2; bus.next_imemaddr_EX_MEM = 32'h1004;
    step();
    chk("npc_wdat", bus.wdat_MEM_WB, 32'h1004);
    idle_inputs();
    // SC behaviour
    bus.dmemREN_EX_MEM = 1; bus.datomic_EX_MEM = 1; bus.dmemaddr_EX_MEM = 32'h100; bus.dhit = 1;
    bus.mem_to_reg_EX_MEM = 2'd1; bus.WEN_EX_MEM = 1; bus.reg_dest_EX_MEM = 2'd1; bus.Rt_EX_MEM = 5'd9;
    step();
    bus.dmemREN_EX_MEM = 0; bus.dmemWEN_EX_MEM = 1; bus.mem_to_reg_EX_MEM = 2'd0;
    bus.result_EX_MEM = 32'hABC;
    #1;
    chk("sc1_wen", bus.dmemWEN, 1);
    step();
`ifdef LLSC_EN
    chk("sc1_wdat", bus.wdat_MEM_WB, 1);
    bus.dhit = 0;
    #1;
    chk("sc2_wen", bus.dmemWEN, 0);
    chk("sc2_stall", bus.mem_stall, 0);
    step();
    chk("sc2_wdat", bus.wdat_MEM_WB, 0);
`else
    chk("sc1_wdat", bus.wdat_MEM_WB, 32'hABC);
`endif
    idle_inputs();
    // reset while waiting on a miss
    bus.dmemREN_EX_MEM = 1; bus.dmemaddr_EX_MEM = 32'h200;
    step();
    chk("miss_ren", bus.dmemREN, 1);
    chk("miss_stall", bus.mem_stall, 1);
    rst_n = 0;
    #1;
    chk("abort_ren", bus.dmemREN, 0);
    chk("abort_stall", bus.mem_stall, 0);
    chk("abort_wenwb", bus.WEN_MEM_WB, 0);
    step();
    idle_inputs();
    rst_n = 1;
    step();
    // halt is sticky and blocks further strobes
    bus.halt_EX_MEM = 1;
    step();
    chk("halt_set", bus.halt_MEM_WB, 1);
    bus.halt_EX_MEM = 0;
    step();
    chk("halt_sticky", bus.halt_MEM_WB, 1);
    bus.dmemREN_EX_MEM = 1; bus.dmemaddr_EX_MEM = 32'h300;
    #1;
    chk("halt_ren", bus.dmemREN, 0);
    chk("halt_stall", bus.mem_stall, 0);
    step();
    chk("halt_sticky2", bus.halt_MEM_WB, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
